// File: rtl/reg_bank_pkg.sv
// Shared definitions for the register bank controller: opcodes and FSM states.
// Optional feature macro used by the bank: REG_BANK_PARITY_EN (per-entry even parity).
package reg_bank_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_NOP   = 3'b000;
  localparam logic [OP_W-1:0] OP_WRITE = 3'b001;
  localparam logic [OP_W-1:0] OP_READ  = 3'b010;
  localparam logic [OP_W-1:0] OP_MOVE  = 3'b011;
  localparam logic [OP_W-1:0] OP_SWAP  = 3'b100;

  // SWAP2 is the second cycle of a swap, when the saved value lands in reg[src].
  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SWAP2 = 1'b1
  } state_e;

endpackage

// File: rtl/reg_bank_storage.sv
// Register array for the bank: one write port, two asynchronous read ports.
// Entries are opaque ENTRY_W-bit words; the top decides whether a parity bit
// is packed above the data (REG_BANK_PARITY_EN).
module reg_bank_storage #(
  parameter int ENTRY_W = 16,
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic [ADDR_W-1:0]  waddr_i,
  input  logic [ENTRY_W-1:0] wentry_i,
  input  logic [ADDR_W-1:0]  raddr_a_i,
  output logic [ENTRY_W-1:0] rentry_a_o,
  input  logic [ADDR_W-1:0]  raddr_b_i,
  output logic [ENTRY_W-1:0] rentry_b_o
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  // Array state: cleared on reset, single write per cycle, out-of-range writes dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {ENTRY_W{1'b0}};
      end
    end else if (we_i && ({1'b0, waddr_i} < DEPTH_C)) begin
      mem_q[waddr_i] <= wentry_i;
    end
  end

  // Unpopulated indices (DEPTH not a power of two) read as zero.
  assign rentry_a_o = ({1'b0, raddr_a_i} < DEPTH_C) ? mem_q[raddr_a_i] : {ENTRY_W{1'b0}};
  assign rentry_b_o = ({1'b0, raddr_b_i} < DEPTH_C) ? mem_q[raddr_b_i] : {ENTRY_W{1'b0}};

endmodule

// File: rtl/reg_bank_ctrl.sv
// Register bank controller: valid/ready command port executing WRITE, READ,
// MOVE and a two-cycle SWAP on a single-write-port register array.
// Results are registered (latency 1); illegal commands raise a one-cycle err.
// Optional macro REG_BANK_PARITY_EN adds a stored even-parity bit per entry
// and a registered rd_par_err flag; without it rd_par_err is tied low.
module reg_bank_ctrl
  import reg_bank_pkg::*;
#(
  parameter  int DATA_W = 16,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [OP_W-1:0]   cmd_op,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              err,
  output logic              rd_par_err
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

`ifdef REG_BANK_PARITY_EN
  localparam int ENTRY_W = DATA_W + 1;

  // Entry layout is {even_parity, data}.
  function automatic logic [ENTRY_W-1:0] make_entry(input logic [DATA_W-1:0] d);
    return {^d, d};
  endfunction

  function automatic logic entry_par_err(input logic [ENTRY_W-1:0] e);
    return (e[DATA_W] != (^e[DATA_W-1:0]));
  endfunction
`else
  localparam int ENTRY_W = DATA_W;

  function automatic logic [ENTRY_W-1:0] make_entry(input logic [DATA_W-1:0] d);
    return d;
  endfunction
`endif

  function automatic logic idx_ok(input logic [ADDR_W-1:0] idx);
    return ({1'b0, idx} < DEPTH_C);
  endfunction

  state_e             state_q, state_d;
  logic [ENTRY_W-1:0] tmp_q, tmp_d;
  logic [ADDR_W-1:0]  swap_src_q, swap_src_d;
  logic               rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               err_q, err_d;

  logic               accept_s;
  logic               src_ok_s;
  logic               dst_ok_s;
  logic               load_res_s;
  logic               we_s;
  logic [ADDR_W-1:0]  waddr_s;
  logic [ENTRY_W-1:0] wentry_s;
  logic [ENTRY_W-1:0] rentry_src_s;
  logic [ENTRY_W-1:0] rentry_dst_s;

  assign cmd_ready = (state_q == S_IDLE);
  assign accept_s  = cmd_valid & cmd_ready;
  assign src_ok_s  = idx_ok(cmd_src);
  assign dst_ok_s  = idx_ok(cmd_dst);

  reg_bank_storage #(
    .ENTRY_W (ENTRY_W),
    .DEPTH   (DEPTH),
    .ADDR_W  (ADDR_W)
  ) u_storage (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (we_s),
    .waddr_i    (waddr_s),
    .wentry_i   (wentry_s),
    .raddr_a_i  (cmd_src),
    .rentry_a_o (rentry_src_s),
    .raddr_b_i  (cmd_dst),
    .rentry_b_o (rentry_dst_s)
  );

`ifdef REG_BANK_PARITY_EN
  logic rd_par_err_q, rd_par_err_d;
  assign rd_par_err = rd_par_err_q;
`else
  assign rd_par_err = 1'b0;
`endif

  // Command decode, legality check, write-port steering and SWAP sequencing.
  always_comb begin
    state_d    = state_q;
    tmp_d      = tmp_q;
    swap_src_d = swap_src_q;
    we_s       = 1'b0;
    waddr_s    = cmd_dst;
    wentry_s   = make_entry(cmd_wdata);
    load_res_s = 1'b0;
    err_d      = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
`ifdef REG_BANK_PARITY_EN
    rd_par_err_d = rd_par_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          case (cmd_op)
            OP_NOP: begin
            end
            OP_WRITE: begin
              if (dst_ok_s) begin
                we_s = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_READ: begin
              if (src_ok_s) begin
                load_res_s = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_MOVE: begin
              // Whole entry is copied so a corrupted source stays detectable.
              if (src_ok_s && dst_ok_s) begin
                we_s       = 1'b1;
                wentry_s   = rentry_src_s;
                load_res_s = 1'b1;
              end else begin
                err_d = 1'b1;
              end
            end
            OP_SWAP: begin
              // First half: save reg[dst], overwrite it with reg[src].
              if (src_ok_s && dst_ok_s) begin
                we_s       = 1'b1;
                wentry_s   = rentry_src_s;
                tmp_d      = rentry_dst_s;
                swap_src_d = cmd_src;
                load_res_s = 1'b1;
                state_d    = S_SWAP2;
              end else begin
                err_d = 1'b1;
              end
            end
            default: begin
              err_d = 1'b1;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SWAP2: begin
        // Second half: saved value goes back into reg[src].
        we_s     = 1'b1;
        waddr_s  = swap_src_q;
        wentry_s = tmp_q;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load_res_s) begin
      rd_valid_d = 1'b1;
      rd_data_d  = rentry_src_s[DATA_W-1:0];
`ifdef REG_BANK_PARITY_EN
      rd_par_err_d = entry_par_err(rentry_src_s);
`endif
    end else begin
      rd_valid_d = 1'b0;
    end
  end

  // FSM, swap scratch and registered result/error outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tmp_q      <= {ENTRY_W{1'b0}};
      swap_src_q <= {ADDR_W{1'b0}};
      rd_valid_q <= 1'b0;
      rd_data_q  <= {DATA_W{1'b0}};
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmp_q      <= tmp_d;
      swap_src_q <= swap_src_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      err_q      <= err_d;
    end
  end

`ifdef REG_BANK_PARITY_EN
  // Parity flag travels with rd_data and holds with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_par_err_q <= 1'b0;
    end else begin
      rd_par_err_q <= rd_par_err_d;
    end
  end
`endif

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign err      = err_q;

endmodule

// File: tb/tb_reg_bank_ctrl.sv
// Self-checking bench for reg_bank_ctrl (DEPTH=6 so out-of-range indices are
// reachable). Parity section is compiled only with REG_BANK_PARITY_EN.
module tb_reg_bank_ctrl;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 6;
  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [2:0] T_NOP   = 3'b000;
  localparam logic [2:0] T_WRITE = 3'b001;
  localparam logic [2:0] T_READ  = 3'b010;
  localparam logic [2:0] T_MOVE  = 3'b011;
  localparam logic [2:0] T_SWAP  = 3'b100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [2:0]        cmd_op = 3'b000;
  logic [ADDR_W-1:0] cmd_src = '0;
  logic [ADDR_W-1:0] cmd_dst = '0;
  logic [DATA_W-1:0] cmd_wdata = '0;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              err;
  logic              rd_par_err;

  int checks = 0;
  int failures = 0;

  // Reference model: register contents, corruption marks, swap-busy flag, expected outputs.
  logic [DATA_W-1:0] m_regs [8];
  logic              m_bad  [8];
  logic              m_busy;
  logic              exp_valid;
  logic              exp_err;
  logic              exp_par;
  logic [DATA_W-1:0] exp_data;

  reg_bank_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_src    (cmd_src),
    .cmd_dst    (cmd_dst),
    .cmd_wdata  (cmd_wdata),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .err        (err),
    .rd_par_err (rd_par_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 8; i++) begin
      m_regs[i] = '0;
      m_bad[i]  = 1'b0;
    end
    m_busy   = 1'b0;
    exp_data = '0;
    exp_par  = 1'b0;
  endtask

  // One clock of stimulus, called at a negedge; returns at the following negedge
  // after checking the registered outputs against the model.
  task automatic step(input logic v, input logic [2:0] op, input logic [2:0] s,
                      input logic [2:0] d, input logic [DATA_W-1:0] wd, input string tag);
    logic              acc;
    logic              s_ok;
    logic              d_ok;
    logic [DATA_W-1:0] tmp;
    logic              tmp_bad;
    cmd_valid = v;
    cmd_op    = op;
    cmd_src   = s;
    cmd_dst   = d;
    cmd_wdata = wd;
    chk({tag, "/ready"}, 32'(cmd_ready), 32'(!m_busy));
    acc       = v && !m_busy;
    s_ok      = (int'(s) < DEPTH);
    d_ok      = (int'(d) < DEPTH);
    exp_valid = 1'b0;
    exp_err   = 1'b0;
    if (m_busy) begin
      m_busy = 1'b0;
    end else if (acc) begin
      case (op)
        T_NOP: begin
        end
        T_WRITE: begin
          if (d_ok) begin
            m_regs[d] = wd;
            m_bad[d]  = 1'b0;
          end else exp_err = 1'b1;
        end
        T_READ: begin
          if (s_ok) begin
            exp_valid = 1'b1;
            exp_data  = m_regs[s];
            exp_par   = m_bad[s];
          end else exp_err = 1'b1;
        end
        T_MOVE: begin
          if (s_ok && d_ok) begin
            exp_valid = 1'b1;
            exp_data  = m_regs[s];
            exp_par   = m_bad[s];
            m_regs[d] = m_regs[s];
            m_bad[d]  = m_bad[s];
          end else exp_err = 1'b1;
        end
        T_SWAP: begin
          if (s_ok && d_ok) begin
            exp_valid = 1'b1;
            exp_data  = m_regs[s];
            exp_par   = m_bad[s];
            tmp       = m_regs[d];
            tmp_bad   = m_bad[d];
            m_regs[d] = m_regs[s];
            m_bad[d]  = m_bad[s];
            m_regs[s] = tmp;
            m_bad[s]  = tmp_bad;
            m_busy    = 1'b1;
          end else exp_err = 1'b1;
        end
        default: exp_err = 1'b1;
      endcase
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, "/rd_valid"}, 32'(rd_valid), 32'(exp_valid));
    chk({tag, "/err"}, 32'(err), 32'(exp_err));
    chk({tag, "/rd_data"}, 32'(rd_data), 32'(exp_data));
    chk({tag, "/rd_par_err"}, 32'(rd_par_err), 32'(exp_par));
    cmd_valid = 1'b0;
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, T_READ, 3'(i), 3'd0, 16'h0000, tag);
    end
  endtask

  initial begin
    m_reset();

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset/ready", 32'(cmd_ready), 32'd1);
    chk("reset/rd_valid", 32'(rd_valid), 32'd0);
    chk("reset/rd_data", 32'(rd_data), 32'd0);
    chk("reset/err", 32'(err), 32'd0);
    chk("reset/rd_par_err", 32'(rd_par_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Read of a cleared register
    step(1'b1, T_READ, 3'd3, 3'd0, 16'h0000, "t1_read3");

    // Writes followed by reads; first read is immediately after a write (RAW)
    step(1'b1, T_WRITE, 3'd0, 3'd1, 16'd21, "t2_wr1");
    step(1'b1, T_WRITE, 3'd0, 3'd2, 16'd253, "t2_wr2");
    step(1'b1, T_READ, 3'd2, 3'd0, 16'h0000, "t2_raw2");
    step(1'b1, T_READ, 3'd1, 3'd0, 16'h0000, "t2_rd1");

    // MOVE returns pre-move source value; source keeps its value
    step(1'b1, T_MOVE, 3'd1, 3'd3, 16'h0000, "t3_move");
    step(1'b1, T_READ, 3'd3, 3'd0, 16'h0000, "t3_rd3");
    step(1'b1, T_READ, 3'd1, 3'd0, 16'h0000, "t3_rd1");
    step(1'b1, T_MOVE, 3'd2, 3'd2, 16'h0000, "t3_move_same");

    // SWAP with valid held: one stalled cycle, then the retried READ goes through
    step(1'b1, T_SWAP, 3'd1, 3'd2, 16'h0000, "t4_swap");
    step(1'b1, T_READ, 3'd1, 3'd0, 16'h0000, "t4_stall");
    step(1'b1, T_READ, 3'd1, 3'd0, 16'h0000, "t4_rd1");
    step(1'b1, T_READ, 3'd2, 3'd0, 16'h0000, "t4_rd2");
    step(1'b1, T_SWAP, 3'd4, 3'd4, 16'h0000, "t4_swap_same");
    step(1'b0, T_NOP, 3'd0, 3'd0, 16'h0000, "t4_idle");
    step(1'b1, T_NOP, 3'd0, 3'd0, 16'h0000, "t4_nop");

    // Illegal commands: error pulse only, contents untouched
    step(1'b1, T_READ, 3'd7, 3'd0, 16'h0000, "t5_rd7");
    step(1'b1, 3'b110, 3'd1, 3'd2, 16'h0000, "t5_op6");
    step(1'b1, 3'b101, 3'd1, 3'd2, 16'h0000, "t5_op5");
    step(1'b1, 3'b111, 3'd1, 3'd2, 16'h0000, "t5_op7");
    step(1'b1, T_WRITE, 3'd0, 3'd6, 16'hBEEF, "t5_wr6");
    step(1'b1, T_MOVE, 3'd1, 3'd7, 16'h0000, "t5_mv_dst7");
    step(1'b1, T_SWAP, 3'd6, 3'd1, 16'h0000, "t5_sw_src6");
    step(1'b1, T_WRITE, 3'd7, 3'd5, 16'h1234, "t5_wr_src_ignored");
    read_all("t5_readback");

    // Randomized traffic, biased toward legal indices
    for (int n = 0; n < 400; n++) begin
      logic              v;
      logic [2:0]        op;
      logic [2:0]        s;
      logic [2:0]        d;
      logic [DATA_W-1:0] wd;
      v  = ($urandom_range(0, 3) != 0);
      op = 3'($urandom_range(0, 7));
      s  = ($urandom_range(0, 7) != 0) ? 3'($urandom_range(0, DEPTH - 1)) : 3'($urandom_range(0, 7));
      d  = ($urandom_range(0, 7) != 0) ? 3'($urandom_range(0, DEPTH - 1)) : 3'($urandom_range(0, 7));
      wd = 16'($urandom);
      step(v, op, s, d, wd, "rand");
    end
    read_all("rand_readback");

    // Reset while in the second SWAP cycle
    step(1'b1, T_WRITE, 3'd0, 3'd0, 16'hA5A5, "t5_pre_wr0");
    step(1'b1, T_WRITE, 3'd0, 3'd5, 16'h5A5A, "t5_pre_wr5");
    step(1'b1, T_SWAP, 3'd0, 3'd5, 16'h0000, "t5_swap_rst");
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("midswap_rst/ready", 32'(cmd_ready), 32'd1);
    chk("midswap_rst/rd_valid", 32'(rd_valid), 32'd0);
    chk("midswap_rst/rd_data", 32'(rd_data), 32'd0);
    chk("midswap_rst/err", 32'(err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    read_all("t5_after_rst");

`ifdef REG_BANK_PARITY_EN
    // Parity: clean entry, then a flipped stored data bit
    step(1'b1, T_WRITE, 3'd0, 3'd1, 16'h0001, "t6_wr");
    step(1'b1, T_READ, 3'd1, 3'd0, 16'h0000, "t6_rd_clean");
    dut.u_storage.mem_q[1] = {1'b1, 16'h0000};
    m_regs[1] = 16'h0000;
    m_bad[1]  = 1'b1;
    step(1'b1, T_READ, 3'd1, 3'd0, 16'h0000, "t6_rd_bad");
    step(1'b1, T_MOVE, 3'd1, 3'd2, 16'h0000, "t6_mv_bad");
    step(1'b1, T_READ, 3'd2, 3'd0, 16'h0000, "t6_rd_moved");
    step(1'b1, T_WRITE, 3'd0, 3'd1, 16'h0003, "t6_rewrite");
    step(1'b1, T_READ, 3'd1, 3'd0, 16'h0000, "t6_rd_fixed");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
